sar_controller: RTL and testbench

Successive-approximation controller for the discrete ADC. It drives the trial code into `sar_duty_cycle` of `sawtooth_generator`, which is run with `adc_mode` = 1, so the code reaches the R-2R/PWM DAC. It reads the external analog comparator and resolves one bit per trial, MSB first. When the conversion finishes it presents a `WIDTH`-bit result with a one-cycle `done` pulse, in single-shot or continuous mode.

---
 rtl/sar_controller.sv | 155 +++++++++++++++
 tb/tb_sar_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_controller.sv
// Successive-approximation ADC controller: drives MSB-first trial codes to the DAC
// path, samples a synchronized comparator and publishes each result with a done pulse.
module sar_controller #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             continuous,
    input  logic             comp_in,
    output logic [WIDTH-1:0] sar_duty_cycle,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE   = WIDTH'(1) << (WIDTH - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("sar_controller: SYNC_STAGES must be at least 2");
    end
    if (SETTLE_CYCLES < SYNC_STAGES + 2) begin : g_bad_settle
        $error("sar_controller: SETTLE_CYCLES must be at least SYNC_STAGES + 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] code_kept;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   comp_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], comp_in};
        end
    end

    assign comp_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            code_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Handshake: start is accepted only in IDLE with enable high (never queued);
    // done is a single-cycle pulse coincident with result taking its new value.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        result_d  = result_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_mask  = WIDTH'(1) << idx_q;
        code_kept = comp_s ? code_q : (code_q & ~bit_mask);

        if (!enable) begin
            state_d = IDLE;
            code_d  = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SETTLE;
                        code_d  = MSB_CODE;
                        idx_d   = IDX_MSB;
                        cnt_d   = CNT_RELOAD;
                        busy_d  = 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (idx_q != '0) begin
                        idx_d   = idx_q - IDX_W'(1);
                        code_d  = code_kept | (bit_mask >> 1);
                        cnt_d   = CNT_RELOAD;
                        state_d = SETTLE;
                    end else begin
                        result_d = code_kept;
                        done_d   = 1'b1;
                        if (continuous) begin
                            // Back-to-back conversion: no idle cycle, busy stays high.
                            code_d  = MSB_CODE;
                            idx_d   = IDX_MSB;
                            cnt_d   = CNT_RELOAD;
                            state_d = SETTLE;
                        end else begin
                            code_d  = '0;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    code_d  = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign sar_duty_cycle = code_q;
    assign result         = result_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_sar_controller.sv
// Bench for sar_controller: comparator and DAC-delay model around the DUT, ideal
// binary-search reference for trial codes and results, randomized input levels.
module tb_sar_controller;

    localparam int W    = 8;
    localparam int SC   = 4;
    localparam int SS   = 2;
    localparam int CONV = W * (SC + 1);

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         start;
    logic         continuous;
    logic         comp_in = 1'b0;
    logic [W-1:0] sar_duty_cycle;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic [1:0]   state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] vin    = '0;
    logic [W-1:0] dac_d  = '0;
    bit           jitter = 1'b0;

    // Scoreboard queues
    logic [W-1:0] exp_q[$];
    logic [W-1:0] trial_q[$];
    int           trial_cyc_q[$];
    int           done_cyc_q[$];
    logic [W-1:0] done_res_q[$];
    logic [W-1:0] last_dc = '0;
    bit           watch_busy = 1'b0;
    bit           busy_dropped = 1'b0;

    sar_controller #(
        .WIDTH(W),
        .SETTLE_CYCLES(SC),
        .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .start(start),
        .continuous(continuous),
        .comp_in(comp_in),
        .sar_duty_cycle(sar_duty_cycle),
        .result(result),
        .done(done),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    // Clock / reset-independent environment
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DAC path register: comparator sees the trial code one clock late.
    always @(posedge clk) dac_d <= sar_duty_cycle;

    always @(posedge clk) begin : comparator
        int d;
        d = jitter ? int'($urandom_range(1, 8)) : 1;
        #(d);
        comp_in = (vin >= dac_d);
    end

    always @(negedge clk) begin : monitor
        if (done) begin
            done_cyc_q.push_back(cyc);
            done_res_q.push_back(result);
        end
        if (sar_duty_cycle != last_dc) begin
            if (sar_duty_cycle != '0) begin
                trial_q.push_back(sar_duty_cycle);
                trial_cyc_q.push_back(cyc);
            end
            last_dc = sar_duty_cycle;
        end
        if (watch_busy && !busy) busy_dropped = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Ideal binary search: every trial adds the next lower bit to the accepted code.
    function automatic logic [W-1:0] model_convert(input logic [W-1:0] v);
        int code;
        int trial;
        code = 0;
        for (int b = W - 1; b >= 0; b--) begin
            trial = code + (1 << b);
            exp_q.push_back(W'(trial));
            if (int'(v) >= trial) code = trial;
        end
        return W'(code);
    endfunction

    task automatic clear_mon();
        exp_q.delete();
        trial_q.delete();
        trial_cyc_q.delete();
        done_cyc_q.delete();
        done_res_q.delete();
        busy_dropped = 1'b0;
    endtask

    task automatic do_start(input string tag, output int e0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
        check({tag, "_start_busy"}, 32'(busy), 32'd1);
        check({tag, "_start_code"}, 32'(sar_duty_cycle), 32'h80);
    endtask

    task automatic run_single(input logic [W-1:0] v, input string tag);
        int           e0;
        logic [W-1:0] exp_res;
        clear_mon();
        vin     = v;
        exp_res = model_convert(v);
        repeat (2) @(negedge clk);
        do_start(tag, e0);
        repeat (CONV + 5) @(negedge clk);
        check({tag, "_done_count"}, 32'(done_cyc_q.size()), 32'd1);
        if (done_cyc_q.size() > 0) begin
            check({tag, "_done_cycle"}, 32'(done_cyc_q[0] - e0), 32'(CONV));
            check({tag, "_done_result"}, 32'(done_res_q[0]), 32'(exp_res));
        end
        check({tag, "_result_ideal"}, 32'(result), 32'(v));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_code_after"}, 32'(sar_duty_cycle), 32'd0);
        check({tag, "_trial_count"}, 32'(trial_q.size()), 32'(W));
        for (int i = 0; i < W && i < trial_q.size(); i++) begin
            check({tag, "_trial"}, 32'(trial_q[i]), 32'(exp_q[i]));
            check({tag, "_trial_cycle"}, 32'(trial_cyc_q[i] - e0), 32'(i * (SC + 1)));
        end
    endtask

    initial begin : main
        int           e0;
        logic [W-1:0] prev;
        logic [W-1:0] v;

        reset      = 1'b1;
        enable     = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_code", 32'(sar_duty_cycle), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Directed single-shot and endpoints
        run_single(8'hA5, "a5");
        run_single(8'h00, "zero");
        run_single(8'hFF, "full");
        run_single(8'h80, "mid");

        // Random levels
        repeat (4) run_single(W'($urandom_range(0, 255)), "rand");

        // Continuous mode with a step in vin during the second conversion
        clear_mon();
        vin        = 8'h3C;
        continuous = 1'b1;
        do_start("cont", e0);
        watch_busy = 1'b1;
        for (int k = 0; k < 4 * CONV + 10; k++) begin
            @(negedge clk);
            if (cyc == e0 + 50) vin = 8'hF0;
            if (cyc == e0 + 3 * CONV + 5) continuous = 1'b0;
            if (cyc == e0 + 4 * CONV - 1) watch_busy = 1'b0;
        end
        check("cont_done_count", 32'(done_cyc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < done_cyc_q.size(); i++) begin
            check("cont_done_cycle", 32'(done_cyc_q[i] - e0), 32'((i + 1) * CONV));
        end
        if (done_res_q.size() == 4) begin
            check("cont_res0", 32'(done_res_q[0]), 32'h3C);
            check("cont_res2", 32'(done_res_q[2]), 32'hF0);
            check("cont_res3", 32'(done_res_q[3]), 32'hF0);
        end
        check("cont_busy_held", 32'(busy_dropped), 32'd0);
        check("cont_busy_end", 32'(busy), 32'd0);

        // Abort by enable low at clock 17
        prev = result;
        clear_mon();
        vin = W'($urandom_range(0, 255));
        do_start("abort", e0);
        repeat (16) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_code", 32'(sar_duty_cycle), 32'd0);
        check("abort_result", 32'(result), 32'(prev));
        check("abort_done", 32'(done), 32'd0);
        repeat (CONV) @(negedge clk);
        check("abort_no_done", 32'(done_cyc_q.size()), 32'd0);
        enable = 1'b1;

        // Start while busy is ignored
        clear_mon();
        vin = 8'h6B;
        do_start("restart", e0);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * CONV) @(negedge clk);
        check("restart_done_count", 32'(done_cyc_q.size()), 32'd1);
        if (done_cyc_q.size() > 0) begin
            check("restart_done_cycle", 32'(done_cyc_q[0] - e0), 32'(CONV));
        end
        check("restart_result", 32'(result), 32'h6B);
        check("restart_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-conversion
        clear_mon();
        vin = 8'hC3;
        do_start("areset", e0);
        repeat (25) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_code", 32'(sar_duty_cycle), 32'd0);
        check("areset_result", 32'(result), 32'd0);
        check("areset_done", 32'(done), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        v = W'($urandom_range(0, 255));
        run_single(v, "post_reset");

        // Comparator edges at random points within the clock
        jitter = 1'b1;
        run_single(8'h5A, "jitter");
        repeat (2) run_single(W'($urandom_range(0, 255)), "jitter_rand");
        jitter = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
